// File: rtl/axi_mem_txn_throttle.sv
// AXI memory-port throttle: caps outstanding read/write bursts, holds W until its AW
// has been accepted, and regenerates WLAST from the accepted AWLEN.
module axi_mem_txn_throttle #(
    parameter int MAX_RD = 4,
    parameter int MAX_WR = 4,
    parameter int ID_W   = 6,
    parameter int DATA_W = 64,
    localparam int ARW_BITS = 32 + ID_W + 8 + 3 + 2 + 1 + 4 + 3 + 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  s_ar_valid,
    input  logic [ARW_BITS-1:0]   s_ar_bits,
    output logic                  s_ar_ready,
    output logic                  m_ar_valid,
    output logic [ARW_BITS-1:0]   m_ar_bits,
    input  logic                  m_ar_ready,

    input  logic                  s_aw_valid,
    input  logic [ARW_BITS-1:0]   s_aw_bits,
    output logic                  s_aw_ready,
    output logic                  m_aw_valid,
    output logic [ARW_BITS-1:0]   m_aw_bits,
    input  logic                  m_aw_ready,

    input  logic                  s_w_valid,
    input  logic [DATA_W-1:0]     s_w_data,
    input  logic [DATA_W/8-1:0]   s_w_strb,
    input  logic                  s_w_last,
    output logic                  s_w_ready,
    output logic                  m_w_valid,
    output logic [DATA_W-1:0]     m_w_data,
    output logic [DATA_W/8-1:0]   m_w_strb,
    output logic                  m_w_last,
    input  logic                  m_w_ready,

    input  logic                  m_r_valid,
    input  logic [ID_W-1:0]       m_r_id,
    input  logic [DATA_W-1:0]     m_r_data,
    input  logic [1:0]            m_r_resp,
    input  logic                  m_r_last,
    output logic                  m_r_ready,
    output logic                  s_r_valid,
    output logic [ID_W-1:0]       s_r_id,
    output logic [DATA_W-1:0]     s_r_data,
    output logic [1:0]            s_r_resp,
    output logic                  s_r_last,
    input  logic                  s_r_ready,

    input  logic                  m_b_valid,
    input  logic [ID_W-1:0]       m_b_id,
    input  logic [1:0]            m_b_resp,
    output logic                  m_b_ready,
    output logic                  s_b_valid,
    output logic [ID_W-1:0]       s_b_id,
    output logic [1:0]            s_b_resp,
    input  logic                  s_b_ready,

    output logic [3:0]            rd_outstanding,
    output logic [3:0]            wr_outstanding,
    output logic                  err_wlast,
    output logic                  err_orphan
);

    localparam int               LEN_LO   = ID_W + 32;
    localparam int               PTR_W    = (MAX_WR > 1) ? $clog2(MAX_WR) : 1;
    localparam logic [3:0]       MAX_RD_C = 4'(MAX_RD);
    localparam logic [3:0]       MAX_WR_C = 4'(MAX_WR);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_WR - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [3:0]       rd_cnt_q, rd_cnt_d;
    logic [3:0]       wr_cnt_q, wr_cnt_d;
    logic [7:0]       wq_mem_q [MAX_WR];
    logic [PTR_W-1:0] wq_rd_q, wq_rd_d;
    logic [PTR_W-1:0] wq_wr_q, wq_wr_d;
    logic [3:0]       wq_cnt_q, wq_cnt_d;
    logic [7:0]       beat_q, beat_d;
    logic             err_wlast_q, err_wlast_d;
    logic             err_orphan_q, err_orphan_d;

    logic       rd_ok, wr_ok, w_ok;
    logic       ar_hs, aw_hs, w_hs, r_last_hs, b_hs;
    logic       wq_push, w_pop;
    logic [7:0] head_len;

    // Every handshake is gated by reset so nothing leaks out while the slave is reset too.
    assign rd_ok = !reset && (rd_cnt_q < MAX_RD_C);
    assign wr_ok = !reset && (wr_cnt_q < MAX_WR_C);
    assign w_ok  = !reset && (wq_cnt_q != 4'd0);

    assign m_ar_valid = s_ar_valid & rd_ok;
    assign s_ar_ready = m_ar_ready & rd_ok;
    assign m_ar_bits  = s_ar_bits;

    assign m_aw_valid = s_aw_valid & wr_ok;
    assign s_aw_ready = m_aw_ready & wr_ok;
    assign m_aw_bits  = s_aw_bits;

    assign head_len  = wq_mem_q[wq_rd_q];
    assign m_w_valid = s_w_valid & w_ok;
    assign s_w_ready = m_w_ready & w_ok;
    assign m_w_last  = w_ok & (beat_q == head_len);
    assign m_w_data  = s_w_data;
    assign m_w_strb  = s_w_strb;

    assign s_r_valid = m_r_valid & !reset;
    assign m_r_ready = s_r_ready & !reset;
    assign s_r_id    = m_r_id;
    assign s_r_data  = m_r_data;
    assign s_r_resp  = m_r_resp;
    assign s_r_last  = m_r_last;

    assign s_b_valid = m_b_valid & !reset;
    assign m_b_ready = s_b_ready & !reset;
    assign s_b_id    = m_b_id;
    assign s_b_resp  = m_b_resp;

    assign ar_hs     = s_ar_valid & s_ar_ready;
    assign aw_hs     = s_aw_valid & s_aw_ready;
    assign w_hs      = s_w_valid & s_w_ready;
    assign r_last_hs = m_r_valid & m_r_ready & m_r_last;
    assign b_hs      = m_b_valid & m_b_ready;
    assign wq_push   = aw_hs & (wq_cnt_q != MAX_WR_C);
    assign w_pop     = w_hs & m_w_last;

    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        err_orphan_d = err_orphan_q;
        if (ar_hs && !r_last_hs) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
        end else if (r_last_hs && !ar_hs) begin
            if (rd_cnt_q == 4'd0) err_orphan_d = 1'b1;
            else                  rd_cnt_d     = rd_cnt_q - 4'd1;
        end
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
        end else if (b_hs && !aw_hs) begin
            if (wr_cnt_q == 4'd0) err_orphan_d = 1'b1;
            else                  wr_cnt_d     = wr_cnt_q - 4'd1;
        end
    end

    always_comb begin
        wq_wr_d     = wq_wr_q;
        wq_rd_d     = wq_rd_q;
        wq_cnt_d    = wq_cnt_q;
        beat_d      = beat_q;
        err_wlast_d = err_wlast_q;
        if (wq_push) begin
            wq_wr_d = (wq_wr_q == PTR_LAST) ? '0 : wq_wr_q + PTR_ONE;
        end
        if (w_hs) begin
            if (s_w_last != m_w_last) err_wlast_d = 1'b1;
            if (m_w_last) begin
                beat_d  = 8'd0;
                wq_rd_d = (wq_rd_q == PTR_LAST) ? '0 : wq_rd_q + PTR_ONE;
            end else begin
                beat_d  = beat_q + 8'd1;
            end
        end
        case ({wq_push, w_pop})
            2'b10:   wq_cnt_d = wq_cnt_q + 4'd1;
            2'b01:   wq_cnt_d = wq_cnt_q - 4'd1;
            default: wq_cnt_d = wq_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt_q     <= 4'd0;
            wr_cnt_q     <= 4'd0;
            wq_rd_q      <= '0;
            wq_wr_q      <= '0;
            wq_cnt_q     <= 4'd0;
            beat_q       <= 8'd0;
            err_wlast_q  <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            wq_rd_q      <= wq_rd_d;
            wq_wr_q      <= wq_wr_d;
            wq_cnt_q     <= wq_cnt_d;
            beat_q       <= beat_d;
            err_wlast_q  <= err_wlast_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Length storage needs no reset: an entry is only read once the count says it is live.
    always_ff @(posedge clock) begin
        if (wq_push) wq_mem_q[wq_wr_q] <= s_aw_bits[LEN_LO +: 8];
    end

    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;
    assign err_wlast      = err_wlast_q;
    assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_axi_mem_txn_throttle.sv
// Bench for axi_mem_txn_throttle: directed scenarios plus randomized traffic, checked by a
// negedge monitor against a count/queue reference model and payload scoreboards.
module tb_axi_mem_txn_throttle;

    localparam int MAX_RD   = 4;
    localparam int MAX_WR   = 4;
    localparam int ID_W     = 6;
    localparam int DATA_W   = 64;
    localparam int ARW_BITS = 32 + ID_W + 25;
    localparam int LEN_LO   = ID_W + 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic s_ar_valid = 0, s_ar_ready, m_ar_valid, m_ar_ready = 0;
    logic [ARW_BITS-1:0] s_ar_bits = '0, m_ar_bits;
    logic s_aw_valid = 0, s_aw_ready, m_aw_valid, m_aw_ready = 0;
    logic [ARW_BITS-1:0] s_aw_bits = '0, m_aw_bits;
    logic s_w_valid = 0, s_w_ready, m_w_valid, m_w_ready = 0, s_w_last = 0, m_w_last;
    logic [DATA_W-1:0] s_w_data = '0, m_w_data;
    logic [DATA_W/8-1:0] s_w_strb = '0, m_w_strb;
    logic m_r_valid = 0, m_r_ready, s_r_valid, s_r_ready = 0, m_r_last = 0, s_r_last;
    logic [ID_W-1:0] m_r_id = '0, s_r_id;
    logic [DATA_W-1:0] m_r_data = '0, s_r_data;
    logic [1:0] m_r_resp = '0, s_r_resp;
    logic m_b_valid = 0, m_b_ready, s_b_valid, s_b_ready = 0;
    logic [ID_W-1:0] m_b_id = '0, s_b_id;
    logic [1:0] m_b_resp = '0, s_b_resp;
    logic [3:0] rd_outstanding, wr_outstanding;
    logic err_wlast, err_orphan;

    always #5 clock = ~clock;

    axi_mem_txn_throttle #(.MAX_RD(MAX_RD), .MAX_WR(MAX_WR), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .s_ar_valid(s_ar_valid), .s_ar_bits(s_ar_bits), .s_ar_ready(s_ar_ready),
        .m_ar_valid(m_ar_valid), .m_ar_bits(m_ar_bits), .m_ar_ready(m_ar_ready),
        .s_aw_valid(s_aw_valid), .s_aw_bits(s_aw_bits), .s_aw_ready(s_aw_ready),
        .m_aw_valid(m_aw_valid), .m_aw_bits(m_aw_bits), .m_aw_ready(m_aw_ready),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_w_ready(s_w_ready),
        .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_w_ready(m_w_ready),
        .m_r_valid(m_r_valid), .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
        .m_r_last(m_r_last), .m_r_ready(m_r_ready),
        .s_r_valid(s_r_valid), .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_r_last(s_r_last), .s_r_ready(s_r_ready),
        .m_b_valid(m_b_valid), .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_ready(m_b_ready),
        .s_b_valid(s_b_valid), .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .err_wlast(err_wlast), .err_orphan(err_orphan)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: burst counts, queue of accepted AWLENs, beat index within head burst.
    int  mrd = 0, mwr = 0, mbeat = 0, done_w = 0;
    bit  m_err_wl = 0, m_err_or = 0;
    int  wq[$];
    logic [ARW_BITS-1:0] exp_ar[$], exp_aw[$];
    logic [DATA_W-1:0]   exp_w[$];
    bit  ar_acc = 0, aw_acc = 0, w_acc = 0, r_acc = 0, b_acc = 0;
    bit  ar_ok_m, aw_ok_m, w_ok_m, ar_hs_m, aw_hs_m, w_hs_m, rl_hs_m, b_hs_m, exp_last;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_handshakes", {s_ar_ready, m_ar_valid, s_aw_ready, m_aw_valid, s_w_ready,
                                   m_w_valid, s_r_valid, m_r_ready, s_b_valid, m_b_ready}, '0);
            mrd = 0; mwr = 0; mbeat = 0; done_w = 0; m_err_wl = 0; m_err_or = 0;
            wq.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
            ar_acc = 0; aw_acc = 0; w_acc = 0; r_acc = 0; b_acc = 0;
        end else begin
            ar_ok_m = (mrd < MAX_RD);
            aw_ok_m = (mwr < MAX_WR);
            w_ok_m  = (wq.size() > 0);
            ar_hs_m = s_ar_valid && m_ar_ready && ar_ok_m;
            aw_hs_m = s_aw_valid && m_aw_ready && aw_ok_m;
            w_hs_m  = s_w_valid && m_w_ready && w_ok_m;
            rl_hs_m = m_r_valid && s_r_ready && m_r_last;
            b_hs_m  = m_b_valid && s_b_ready;

            chk("s_ar_ready", s_ar_ready, m_ar_ready && ar_ok_m);
            chk("m_ar_valid", m_ar_valid, s_ar_valid && ar_ok_m);
            chk("s_aw_ready", s_aw_ready, m_aw_ready && aw_ok_m);
            chk("m_aw_valid", m_aw_valid, s_aw_valid && aw_ok_m);
            chk("s_w_ready", s_w_ready, m_w_ready && w_ok_m);
            chk("m_w_valid", m_w_valid, s_w_valid && w_ok_m);
            chk("r_handshake", {s_r_valid, m_r_ready}, {m_r_valid, s_r_ready});
            chk("b_handshake", {s_b_valid, m_b_ready}, {m_b_valid, s_b_ready});
            if (m_r_valid) chk("r_payload", {s_r_id, s_r_data, s_r_resp, s_r_last},
                               {m_r_id, m_r_data, m_r_resp, m_r_last});
            if (m_b_valid) chk("b_payload", {s_b_id, s_b_resp}, {m_b_id, m_b_resp});
            chk("rd_outstanding", rd_outstanding, 4'(mrd));
            chk("wr_outstanding", wr_outstanding, 4'(mwr));
            chk("err_wlast", err_wlast, m_err_wl);
            chk("err_orphan", err_orphan, m_err_or);

            if (ar_hs_m) begin
                if (exp_ar.size() == 0) begin
                    n_chk++; $display("FAIL ar_scoreboard: handshake with nothing expected");
                end else chk("m_ar_bits", m_ar_bits, exp_ar.pop_front());
            end
            if (aw_hs_m) begin
                if (exp_aw.size() == 0) begin
                    n_chk++; $display("FAIL aw_scoreboard: handshake with nothing expected");
                end else chk("m_aw_bits", m_aw_bits, exp_aw.pop_front());
            end
            if (w_hs_m) begin
                exp_last = (mbeat == wq[0]);
                chk("m_w_last", m_w_last, exp_last);
                chk("m_w_strb", m_w_strb, s_w_strb);
                if (exp_w.size() == 0) begin
                    n_chk++; $display("FAIL w_scoreboard: beat with nothing expected");
                end else chk("m_w_data", m_w_data, exp_w.pop_front());
                if (s_w_last != exp_last) m_err_wl = 1;
                if (exp_last) begin
                    void'(wq.pop_front()); mbeat = 0; done_w++;
                end else mbeat++;
            end
            if (aw_hs_m) wq.push_back(int'(s_aw_bits[LEN_LO +: 8]));

            if (ar_hs_m && !rl_hs_m) mrd++;
            else if (rl_hs_m && !ar_hs_m) begin
                if (mrd == 0) m_err_or = 1; else mrd--;
            end
            if (aw_hs_m && !b_hs_m) mwr++;
            else if (b_hs_m && !aw_hs_m) begin
                if (mwr == 0) m_err_or = 1; else mwr--;
            end
            if (b_hs_m && done_w > 0) done_w--;

            ar_acc = ar_hs_m; aw_acc = aw_hs_m; w_acc = w_hs_m;
            r_acc = m_r_valid && s_r_ready; b_acc = b_hs_m;
        end
    end

    function automatic logic [ARW_BITS-1:0] mk_arw(input int len);
        logic [ARW_BITS-1:0] b;
        b = ARW_BITS'({$urandom, $urandom});
        b[LEN_LO +: 8] = 8'(len);
        return b;
    endfunction

    // Randomized master/slave driver, runs at posedge+2 so directed code at +1 never races it.
    bit drv_en = 0, rnd_en = 0;
    int w_plan[$];
    int w_left = 0, plen;

    always @(posedge clock) begin
        #2;
        if (drv_en && !reset) begin
            if (ar_acc) s_ar_valid = 0;
            if (!s_ar_valid && rnd_en && $urandom_range(0, 2) == 0) begin
                s_ar_bits = mk_arw($urandom_range(0, 15)); s_ar_valid = 1;
                exp_ar.push_back(s_ar_bits);
            end
            m_ar_ready = ($urandom_range(0, 3) != 0);
            if (aw_acc) s_aw_valid = 0;
            if (!s_aw_valid && rnd_en && $urandom_range(0, 3) == 0) begin
                plen = $urandom_range(0, 3);
                s_aw_bits = mk_arw(plen); s_aw_valid = 1;
                exp_aw.push_back(s_aw_bits); w_plan.push_back(plen);
            end
            m_aw_ready = ($urandom_range(0, 3) != 0);
            if (w_acc) s_w_valid = 0;
            if (!s_w_valid && (w_left > 0 || w_plan.size() > 0) && $urandom_range(0, 3) != 0) begin
                if (w_left == 0) w_left = w_plan.pop_front() + 1;
                s_w_data = {$urandom, $urandom}; s_w_strb = 8'($urandom);
                s_w_last = (w_left == 1); w_left--; s_w_valid = 1;
                exp_w.push_back(s_w_data);
            end
            m_w_ready = ($urandom_range(0, 3) != 0);
            if (r_acc) m_r_valid = 0;
            if (!m_r_valid && mrd > 0 && $urandom_range(0, 2) == 0) begin
                m_r_valid = 1; m_r_last = 1'($urandom_range(0, 1));
                m_r_id = 6'($urandom); m_r_data = {$urandom, $urandom}; m_r_resp = 2'($urandom);
            end
            s_r_ready = ($urandom_range(0, 3) != 0);
            if (b_acc) m_b_valid = 0;
            if (!m_b_valid && done_w > 0 && $urandom_range(0, 2) == 0) begin
                m_b_valid = 1; m_b_id = 6'($urandom); m_b_resp = 2'($urandom);
            end
            s_b_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    function automatic bit idle();
        return !s_ar_valid && !s_aw_valid && !s_w_valid && !m_r_valid && !m_b_valid &&
               mrd == 0 && mwr == 0 && done_w == 0 && w_plan.size() == 0 && w_left == 0;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        drv_en = 1; rnd_en = 0;
        while (!idle() && n < 1000) begin step(); n++; end
        drv_en = 0;
        n_chk++;
        if (idle()) n_pass++;
        else $display("FAIL %s: got busy after %0d cycles expected idle", tag, n);
    endtask

    task automatic set_readies();
        m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1; s_r_ready = 1; s_b_ready = 1;
    endtask

    // One write burst: first W beat shows up `pre` cycles ahead of its AW.
    task automatic aw_then_w(input int len, input int pre, input bit bad_first, input bit do_b,
                             input string tag);
        s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_strb = 8'($urandom);
        s_w_last = bad_first ? 1'b1 : (len == 0);
        exp_w.push_back(s_w_data);
        for (int i = 0; i < pre; i++) begin
            at_neg(); chk({tag, "_w_held"}, s_w_ready, 1'b0); step();
        end
        s_aw_valid = 1; s_aw_bits = mk_arw(len); exp_aw.push_back(s_aw_bits);
        at_neg(); chk({tag, "_aw_ready"}, s_aw_ready, 1'b1); chk({tag, "_w_held"}, s_w_ready, 1'b0);
        step(); s_aw_valid = 0;
        for (int b = 0; b <= len; b++) begin
            if (b > 0) begin
                s_w_data = {$urandom, $urandom}; s_w_last = (b == len); exp_w.push_back(s_w_data);
            end
            at_neg();
            chk({tag, "_w_ready"}, s_w_ready, 1'b1);
            chk({tag, "_m_w_last"}, m_w_last, b == len);
            step();
        end
        s_w_valid = 0;
        if (do_b) begin
            m_b_valid = 1; at_neg(); step(); m_b_valid = 0;
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 0;
        at_neg();
        chk("reset_rd_outstanding", rd_outstanding, 4'd0);
        chk("reset_errors", {err_wlast, err_orphan}, 2'b00);
        step();

        // Read cap: four accepted, fifth/sixth held until an R-last retires one.
        set_readies();
        for (int k = 0; k < 4; k++) begin
            s_ar_valid = 1; s_ar_bits = mk_arw(k); exp_ar.push_back(s_ar_bits);
            at_neg(); chk("t1_accept", s_ar_ready, 1'b1); step();
        end
        s_ar_bits = mk_arw(4); exp_ar.push_back(s_ar_bits);
        for (int k = 0; k < 2; k++) begin
            at_neg(); chk("t1_full", s_ar_ready, 1'b0); step();
        end
        chk("t1_rd_outstanding", rd_outstanding, 4'd4);
        m_r_valid = 1; m_r_last = 1; m_r_data = {$urandom, $urandom};
        at_neg(); chk("t1_full_during_r", s_ar_ready, 1'b0); step();
        m_r_valid = 0;
        at_neg(); chk("t1_reopen", s_ar_ready, 1'b1); step();
        s_ar_bits = mk_arw(5); exp_ar.push_back(s_ar_bits);
        at_neg(); chk("t1_full6", s_ar_ready, 1'b0); chk("t1_rd_out6", rd_outstanding, 4'd4); step();
        drain("t1_drain");

        // W ahead of AW, then AW with a premature s_w_last.
        set_readies();
        aw_then_w(3, 3, 0, 1, "t2");
        at_neg(); chk("t2_err_wlast", err_wlast, 1'b0); step();
        aw_then_w(1, 0, 1, 1, "t3");
        at_neg(); chk("t3_err_wlast", err_wlast, 1'b1); step();

        // Simultaneous increment and decrement.
        set_readies();
        for (int k = 0; k < 2; k++) begin
            s_ar_valid = 1; s_ar_bits = mk_arw(0); exp_ar.push_back(s_ar_bits); at_neg(); step();
        end
        s_ar_bits = mk_arw(0); exp_ar.push_back(s_ar_bits);
        m_r_valid = 1; m_r_last = 1;
        at_neg(); chk("t4_ar_ready", s_ar_ready, 1'b1); step();
        s_ar_valid = 0; m_r_valid = 0;
        at_neg(); chk("t4_rd_same", rd_outstanding, 4'd2); step();
        aw_then_w(0, 0, 0, 0, "t4a");
        aw_then_w(0, 0, 0, 0, "t4b");
        s_aw_valid = 1; s_aw_bits = mk_arw(0); exp_aw.push_back(s_aw_bits); m_b_valid = 1;
        at_neg(); chk("t4_aw_ready", s_aw_ready, 1'b1); step();
        s_aw_valid = 0; m_b_valid = 0;
        at_neg(); chk("t4_wr_same", wr_outstanding, 4'd2); step();
        s_w_valid = 1; s_w_data = {$urandom, $urandom}; s_w_last = 1; exp_w.push_back(s_w_data);
        at_neg(); chk("t4_w_last", m_w_last, 1'b1); step();
        s_w_valid = 0;
        drain("t4_drain");

        // Orphan B.
        set_readies();
        m_b_valid = 1; at_neg(); step(); m_b_valid = 0;
        at_neg();
        chk("t5_wr_zero", wr_outstanding, 4'd0);
        chk("t5_err_orphan", err_orphan, 1'b1);
        step();

        // Reset in the middle of an 8-beat write burst.
        s_aw_valid = 1; s_aw_bits = mk_arw(7); exp_aw.push_back(s_aw_bits);
        at_neg(); step(); s_aw_valid = 0;
        for (int b = 0; b < 3; b++) begin
            s_w_valid = 1; s_w_last = 0; s_w_data = {$urandom, $urandom}; exp_w.push_back(s_w_data);
            at_neg(); step();
        end
        reset = 1; s_w_valid = 0;
        at_neg(); step();
        reset = 0;
        at_neg();
        chk("t6_counts", {rd_outstanding, wr_outstanding}, 8'h00);
        chk("t6_errors", {err_wlast, err_orphan}, 2'b00);
        chk("t6_outputs", {m_w_valid, m_aw_valid, m_ar_valid}, 3'b000);
        step();
        aw_then_w(0, 2, 0, 1, "t6");

        // Randomized traffic.
        drv_en = 1; rnd_en = 1;
        repeat (3000) step();
        drain("random_drain");

        chk("sb_ar_empty", exp_ar.size(), 0);
        chk("sb_aw_empty", exp_aw.size(), 0);
        chk("sb_w_empty", exp_w.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
